sipo_receiver: RTL and testbench

SIPO_RECEIVER -- requirements
Module: sipo_receiver

---
 rtl/sipo_receiver_pkg.sv | 13 +
 rtl/sipo_shift_core.sv | 48 ++++
 rtl/sipo_receiver.sv | 126 ++++++++++++
 tb/tb_sipo_receiver.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_receiver_pkg.sv
// Shared types and constants for the serial-in parallel-out receiver.
// Holds the FSM state encoding and the shift-direction encodings.
package sipo_receiver_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_e;

    localparam logic LSB_FIRST = 1'b0;
    localparam logic MSB_FIRST = 1'b1;

endpackage

// File: rtl/sipo_shift_core.sv
// Shift register datapath of the SIPO receiver.
// Ports: clk, rst_n (sync, active-low), clear (drop old contents before
// this shift), shift_en, dir (LSB_FIRST/MSB_FIRST), sin, q (register value).
module sipo_shift_core
    import sipo_receiver_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             dir,
    input  logic             sin,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] base;

    // clear together with shift_en starts a fresh word: the first bit
    // lands in an otherwise zeroed register.
    always_comb begin
        base = clear ? '0 : q_q;
        q_d  = q_q;
        if (shift_en) begin
            if (dir == MSB_FIRST) begin
                q_d = {base[WIDTH-2:0], sin};
            end else begin
                q_d = {sin, base[WIDTH-1:1]};
            end
        end else if (clear) begin
            q_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/sipo_receiver.sv
// Serial-in parallel-out receiver with start framing and valid/ready output.
// Ports: clk, rst_n, start, sin_valid, sin, dir in; dout, dout_valid,
// overrun, busy out; dout_ready in (consumer accept).
module sipo_receiver
    import sipo_receiver_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sin_valid,
    input  logic             sin,
    input  logic             dir,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             overrun,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;

    logic             start_fire;
    logic             shift_fire;
    logic             last;
    logic             shift_dir;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] word;

    assign start_fire = sin_valid & start;
    assign shift_fire = sin_valid & ~start & (state_q == RECV);
    assign last       = shift_fire & (cnt_q == LAST);
    // A (re)start uses the live dir; mid-word shifts use the latched one.
    assign shift_dir  = start_fire ? dir : dir_q;

    sipo_shift_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (start_fire),
        .shift_en (start_fire | shift_fire),
        .dir      (shift_dir),
        .sin      (sin),
        .q        (sr)
    );

    // The finished word includes the bit sampled on this same edge, so it
    // is formed from the register plus sin rather than read back later.
    always_comb begin
        if (dir_q == MSB_FIRST) begin
            word = {sr[WIDTH-2:0], sin};
        end else begin
            word = {sin, sr[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        if (start_fire) begin
            state_d = RECV;
            cnt_d   = CW'(1);
            dir_d   = dir;
        end else if (shift_fire) begin
            if (last) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // A new word always wins the output register; overrun only flags a
    // word that was never accepted.
    always_comb begin
        dout_d  = dout_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (valid_q && dout_ready) begin
            valid_d = 1'b0;
        end
        if (last) begin
            dout_d  = word;
            valid_d = 1'b1;
            if (valid_q && !dout_ready) begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= LSB_FIRST;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q == RECV);

endmodule

// File: tb/tb_sipo_receiver.sv
// Scoreboard bench for sipo_receiver: directed scenarios then random traffic
// checked against a bit-list reference model.
module tb_sipo_receiver;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sin_valid = 1'b0;
    logic         sin = 1'b0;
    logic         dir = 1'b0;
    logic         dout_ready = 1'b0;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         overrun;
    logic         busy;

    int tests = 0;
    int fails = 0;
    bit mon_en = 1'b0;

    // Reference model state
    bit           cur[$];
    bit           ldir;
    logic [W-1:0] sb[$];
    logic [W-1:0] m_dout;
    bit           m_ovr;

    sipo_receiver #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .sin_valid  (sin_valid),
        .sin        (sin),
        .dir        (dir),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                     $time);
        end
    endtask

    // Model advance for one rising edge, using the inputs driven for it.
    task automatic model_edge();
        logic [W-1:0] word;
        bit done;
        done = 1'b0;
        word = '0;
        if (!rst_n) begin
            cur.delete();
            sb.delete();
            m_ovr  = 1'b0;
            m_dout = '0;
        end else begin
            if (sin_valid && start) begin
                cur.delete();
                cur.push_back(sin);
                ldir = dir;
            end else if (sin_valid && cur.size() > 0) begin
                cur.push_back(sin);
            end
            if (cur.size() == W) begin
                for (int i = 0; i < W; i++) begin
                    if (ldir) word[W-1-i] = cur[i];
                    else      word[i]     = cur[i];
                end
                cur.delete();
                done = 1'b1;
            end
            if (done) begin
                // Anything still queued here was not accepted: overwritten.
                if (sb.size() > 0) begin
                    m_ovr = 1'b1;
                    void'(sb.pop_back());
                end
                sb.push_back(word);
                m_dout = word;
            end
        end
    endtask

    task automatic cyc(input bit rn, input bit st, input bit sv,
                       input bit s, input bit d, input bit rdy);
        rst_n      = rn;
        start      = st;
        sin_valid  = sv;
        sin        = s;
        dir        = d;
        dout_ready = rdy;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic send(input logic [W-1:0] bits, input bit d,
                        input bit rdy_last);
        for (int i = 0; i < W; i++) begin
            cyc(1, i == 0, 1, bits[W-1-i], d,
                (i == W - 1) ? rdy_last : 1'b0);
        end
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, rdy);
    endtask

    // Monitor: checks every cycle, pops the scoreboard on accept.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (mon_en) begin
            chk("valid", dout_valid, sb.size() > 0);
            chk("dout", dout, m_dout);
            chk("overrun", overrun, m_ovr);
            chk("busy", busy, cur.size() > 0);
            if (sb.size() > 0 && dout_ready) begin
                e = sb.pop_front();
                chk("accept", dout, e);
            end
        end
    end

    initial begin
        // Reset
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        mon_en = 1'b1;
        chk("rst_dout", dout, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_busy", busy, 0);

        // Bit streams written first-to-last, MSB of the literal first.
        send(4'b1011, 0, 0);
        chk("lsb_first", dout, 4'hD);
        chk("lsb_valid", dout_valid, 1);
        idle(1, 1);
        send(4'b1011, 1, 0);
        chk("msb_first", dout, 4'hB);
        idle(1, 1);

        // Stall between bit 1 and bit 2
        cyc(1, 1, 1, 1, 0, 0);
        cyc(1, 0, 1, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 0, 1, 0);
            chk("stall_busy", busy, 1);
            chk("stall_valid", dout_valid, 0);
        end
        cyc(1, 0, 1, 1, 1, 0);
        chk("stall_pre", dout_valid, 0);
        cyc(1, 0, 1, 1, 1, 0);
        chk("stall_dout", dout, 4'hD);
        chk("stall_valid2", dout_valid, 1);
        idle(1, 1);

        // Restart mid-word
        cyc(1, 1, 1, 1, 0, 0);
        cyc(1, 0, 1, 1, 0, 0);
        chk("restart_none", dout_valid, 0);
        send(4'b0110, 0, 0);
        chk("restart_dout", dout, 4'h6);
        idle(1, 1);

        // Overrun
        send(4'b1011, 0, 0);
        send(4'b0110, 0, 0);
        chk("ovr_dout", dout, 4'h6);
        chk("ovr_flag", overrun, 1);
        idle(1, 1);
        chk("ovr_clr_valid", dout_valid, 0);
        chk("ovr_sticky", overrun, 1);
        idle(2, 0);

        // Completion on the accepting edge
        cyc(0, 0, 0, 0, 0, 0);
        chk("rst_ovr", overrun, 0);
        send(4'b1011, 0, 0);
        send(4'b0110, 0, 1);
        chk("same_dout", dout, 4'h6);
        chk("same_valid", dout_valid, 1);
        chk("same_ovr", overrun, 0);
        idle(1, 1);

        // Reset mid-word
        cyc(1, 1, 1, 1, 1, 0);
        cyc(1, 0, 1, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("midrst_dout", dout, 0);
        chk("midrst_valid", dout_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ovr", overrun, 0);
        send(4'b1011, 1, 0);
        chk("post_rst", dout, 4'hB);
        idle(1, 1);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            cyc($urandom_range(0, 99) != 0,
                $urandom_range(0, 5) == 0,
                $urandom_range(0, 3) != 0,
                1'($urandom), 1'($urandom),
                $urandom_range(0, 2) == 0);
        end
        idle(2, 1);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
